vmem_sequencer: RTL and testbench

//  Serialises VLW/VSW vector memory ops onto the single scalar data-memory port.
//  Per op: latches THREADS lane addresses/data and the active-lane mask, issues one access per active lane in ascending lane order,

---
 rtl/vmem_sequencer_pkg.sv | 27 ++
 rtl/vmem_sequencer_if.sv | 30 +++
 rtl/vmem_next_lane.sv | 33 +++
 rtl/vmem_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vmem_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmem_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// vmem_sequencer_pkg
//  Shared types for the vector memory sequencer: the data word, the
//  sequencer state encoding, the default lane count and a helper that sizes
//  lane-index fields.
// ----------------------------------------------------------------------------
package vmem_sequencer_pkg;

  localparam int WORD_W      = 32;
  localparam int THREADS_DEF = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    VM_IDLE,
    VM_ISSUE,
    VM_DONE
  } vmem_state_t;

  typedef logic [THREADS_DEF-1:0] lane_mask_t;

  // Width of a lane index; a single-lane build still needs a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmem_sequencer_if.sv
// ----------------------------------------------------------------------------
// vmem_sequencer_if
//  Scalar data-memory port driven by the vector memory sequencer.
//   dmemREN / dmemWEN : read / write request (held until dhit)
//   dmemaddr          : access address
//   dmemstore         : store data
//   dhit              : memory acknowledge for the current access
//   dload             : read data, valid with dhit
//  master = sequencer side, slave = memory / dcache side.
// ----------------------------------------------------------------------------
interface vmem_sequencer_if;
  import vmem_sequencer_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dload
  );
endinterface

// File: rtl/vmem_next_lane.sv
// ----------------------------------------------------------------------------
// vmem_next_lane
//  Combinational priority encoder over a lane mask.
//   mask       in  : candidate lanes
//   cur        in  : current lane index
//   from_start in  : 1 = lowest set bit overall, 0 = lowest set bit above cur
//   next       out : selected lane index (0 when none)
//   valid      out : a lane was found
// ----------------------------------------------------------------------------
module vmem_next_lane #(
  parameter int THREADS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [THREADS-1:0] mask,
  input  logic [IDX_W-1:0]   cur,
  input  logic               from_start,
  output logic [IDX_W-1:0]   next,
  output logic               valid
);

  // Scanning downward lets the lowest qualifying lane win.
  always_comb begin
    next  = '0;
    valid = 1'b0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        next  = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmem_sequencer.sv
// ----------------------------------------------------------------------------
// vmem_sequencer
//  Serialises VLW/VSW vector memory operations onto the single scalar data
//  memory port. An accepted op latches lane addresses, store data, the active
//  lane mask and the direction, then issues one access per active lane in
//  ascending lane order, collects load data and pulses done with per-lane
//  register-file write strobes.
//
//  Ports
//   CLK, nRST    clock (rising edge), asynchronous active-low reset
//   start        vector memory op present
//   ren / wen    op is a load (VLW) / store (VSW); exactly one must be set
//   lane_mask    active lanes of the op
//   lane_addr    per-lane effective address
//   lane_wdata   per-lane store data
//   dmem         scalar memory port (master modport)
//   stall        hold the pipeline
//   done         one-cycle completion pulse
//   lane_rdata   collected load data
//   lane_wen     per-lane write strobes, valid with done
//   err          one-cycle pulse when start arrives with ren == wen
//
//  Configuration macro VMEM_COALESCE_EN: when defined, a load lane whose
//  address equals the lane currently being accessed takes the same read data
//  without a new access; runs of such lanes chain. Stores never coalesce.
// ----------------------------------------------------------------------------
module vmem_sequencer
  import vmem_sequencer_pkg::*;
#(
  parameter int THREADS = THREADS_DEF
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      start,
  input  logic                      ren,
  input  logic                      wen,
  input  logic [THREADS-1:0]        lane_mask,
  input  word_t [THREADS-1:0]       lane_addr,
  input  word_t [THREADS-1:0]       lane_wdata,
  vmem_sequencer_if.master          dmem,
  output logic                      stall,
  output logic                      done,
  output word_t [THREADS-1:0]       lane_rdata,
  output logic [THREADS-1:0]        lane_wen,
  output logic                      err
);

  localparam int IDX_W = idx_w(THREADS);

  vmem_state_t          state, state_nxt;
  logic [IDX_W-1:0]     cur, cur_nxt;
  logic [THREADS-1:0]   lmask;
  word_t [THREADS-1:0]  laddr;
  word_t [THREADS-1:0]  lwdata;
  logic                 is_load;

  logic                 idle;
  logic                 op_ok;
  logic [THREADS-1:0]   coal_mask;
  logic [THREADS-1:0]   search_mask;
  logic [IDX_W-1:0]     search_cur;
  logic [IDX_W-1:0]     nl_next;
  logic                 nl_valid;

  assign idle  = (state == VM_IDLE);
  assign op_ok = start & (ren ^ wen);

`ifdef VMEM_COALESCE_EN
  // Lanes directly following cur (in active order) that share its address
  // ride along on the current load access.
  always_comb begin
    logic chain;
    coal_mask = '0;
    chain     = is_load;
    for (int i = 0; i < THREADS; i++) begin
      if (lmask[i] && (i > int'(cur))) begin
        if (chain && (laddr[i] == laddr[cur])) begin
          coal_mask[i] = 1'b1;
        end else begin
          chain = 1'b0;
        end
      end
    end
  end
`else
  assign coal_mask = '0;
`endif

  // One encoder serves both searches: the first lane of the incoming mask
  // while idle, and the next un-served lane of the latched mask while issuing.
  assign search_mask = idle ? lane_mask : (lmask & ~coal_mask);
  assign search_cur  = idle ? '0 : cur;

  vmem_next_lane #(
    .THREADS (THREADS),
    .IDX_W   (IDX_W)
  ) u_next_lane (
    .mask       (search_mask),
    .cur        (search_cur),
    .from_start (idle),
    .next       (nl_next),
    .valid      (nl_valid)
  );

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    stall          = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    lane_wen       = '0;
    dmem.dmemREN   = 1'b0;
    dmem.dmemWEN   = 1'b0;
    dmem.dmemaddr  = '0;
    dmem.dmemstore = '0;

    case (state)
      VM_IDLE: begin
        stall = start;
        if (start && (ren == wen)) begin
          err = 1'b1;
        end else if (start) begin
          cur_nxt   = nl_next;
          state_nxt = nl_valid ? VM_ISSUE : VM_DONE;
        end
      end
      VM_ISSUE: begin
        stall          = 1'b1;
        dmem.dmemREN   = is_load;
        dmem.dmemWEN   = ~is_load;
        dmem.dmemaddr  = laddr[cur];
        dmem.dmemstore = lwdata[cur];
        if (dmem.dhit) begin
          if (nl_valid) begin
            cur_nxt = nl_next;
          end else begin
            state_nxt = VM_DONE;
          end
        end
      end
      VM_DONE: begin
        done      = 1'b1;
        lane_wen  = is_load ? lmask : '0;
        state_nxt = VM_IDLE;
      end
      default: state_nxt = VM_IDLE;
    endcase
  end

  // Control: state and current lane.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= VM_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
    end
  end

  // Op latch and load-data collection; cleared on reset so a reset mid-op
  // discards any partially gathered loads.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lmask      <= '0;
      laddr      <= '0;
      lwdata     <= '0;
      is_load    <= 1'b0;
      lane_rdata <= '0;
    end else begin
      if (idle && op_ok) begin
        lmask   <= lane_mask;
        laddr   <= lane_addr;
        lwdata  <= lane_wdata;
        is_load <= ren;
      end
      if ((state == VM_ISSUE) && dmem.dhit && is_load) begin
        for (int i = 0; i < THREADS; i++) begin
          if ((i == int'(cur)) || coal_mask[i]) begin
            lane_rdata[i] <= dmem.dload;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
module tb_vmem_sequencer;
  import vmem_sequencer_pkg::*;

`ifdef VMEM_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct {
    logic  we;
    word_t addr;
    word_t data;
  } acc_t;

  logic        CLK;
  logic        nRST;
  logic        start, ren, wen;
  logic [3:0]  lane_mask;
  word_t [3:0] lane_addr;
  word_t [3:0] lane_wdata;
  logic        stall, done, err;
  word_t [3:0] lane_rdata;
  logic [3:0]  lane_wen;

  vmem_sequencer_if dmem ();

  vmem_sequencer #(.THREADS(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .start      (start),
    .ren        (ren),
    .wen        (wen),
    .lane_mask  (lane_mask),
    .lane_addr  (lane_addr),
    .lane_wdata (lane_wdata),
    .dmem       (dmem),
    .stall      (stall),
    .done       (done),
    .lane_rdata (lane_rdata),
    .lane_wen   (lane_wen),
    .err        (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Default memory contents, distinct per address.
  function automatic word_t dflt(input word_t a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  // Memory environment (acts as the dcache) and the reference model's memory.
  word_t env_mem [word_t];
  word_t ref_mem [word_t];
  acc_t  acc_log [$];
  int    wait_cycles = 0;
  int    wcnt = 0;
  word_t h_addr;
  logic  [1:0] h_dir;

  function automatic word_t env_rd(input word_t a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic word_t ref_rd(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  initial begin
    acc_t e;
    dmem.dhit  = 1'b0;
    dmem.dload = '0;
    forever begin
      @(negedge CLK);
      dmem.dhit  = 1'b0;
      dmem.dload = $urandom;
      if (dmem.dmemREN || dmem.dmemWEN) begin
        if (wcnt > 0) begin
          check_eq("hold_addr", dmem.dmemaddr, h_addr);
          check_eq("hold_dir", {dmem.dmemREN, dmem.dmemWEN}, h_dir);
        end else begin
          h_addr = dmem.dmemaddr;
          h_dir  = {dmem.dmemREN, dmem.dmemWEN};
        end
        if (wcnt >= wait_cycles) begin
          e.we   = dmem.dmemWEN;
          e.addr = dmem.dmemaddr;
          if (dmem.dmemWEN) begin
            e.data = dmem.dmemstore;
            env_mem[e.addr] = e.data;
          end else begin
            e.data     = env_rd(e.addr);
            dmem.dload = e.data;
          end
          dmem.dhit = 1'b1;
          acc_log.push_back(e);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  word_t op_addr  [4];
  word_t op_wdata [4];
  word_t model_rdata [4];

  // Runs one well-formed op and checks it against the reference model.
  task automatic run_op(input logic r, input logic [3:0] m, input int waits);
    acc_t  exp_q [$];
    acc_t  e;
    word_t lead;
    logic  in_chain;
    int    cyc;
    logic  got;

    in_chain = 1'b0;
    lead     = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (r && COAL && in_chain && (op_addr[i] == lead)) begin
          model_rdata[i] = ref_rd(lead);
        end else begin
          e.we   = !r;
          e.addr = op_addr[i];
          e.data = r ? ref_rd(op_addr[i]) : op_wdata[i];
          exp_q.push_back(e);
          lead     = op_addr[i];
          in_chain = 1'b1;
          if (r) model_rdata[i] = ref_rd(op_addr[i]);
          else   ref_mem[op_addr[i]] = op_wdata[i];
        end
      end else begin
        in_chain = in_chain;
      end
    end

    wait_cycles = waits;
    acc_log.delete();
    @(negedge CLK);
    start     = 1'b1;
    ren       = r;
    wen       = !r;
    lane_mask = m;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i]  = op_addr[i];
      lane_wdata[i] = op_wdata[i];
    end
    #1;
    check_eq("stall_on_start", stall, 1'b1);
    check_eq("no_err_valid", err, 1'b0);
    @(posedge CLK);
    #1;
    // Inputs are ignored while the op runs; scramble them.
    start      = $urandom_range(0, 1);
    ren        = $urandom_range(0, 1);
    wen        = $urandom_range(0, 1);
    lane_mask  = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      lane_addr[i]  = $urandom;
      lane_wdata[i] = $urandom;
    end

    cyc = 0;
    got = 1'b0;
    while (cyc < 300 && !got) begin
      @(negedge CLK);
      cyc++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    ren   = 1'b0;
    wen   = 1'b0;
    if (!got) begin
      check_eq("done_timeout", 1'b0, 1'b1);
      return;
    end
    check_eq("latency", cyc, exp_q.size() * (waits + 1) + 1);
    check_eq("lane_wen", lane_wen, r ? m : 4'b0000);
    check_eq("stall_in_done", stall, 1'b0);
    check_eq("strobes_in_done", {dmem.dmemREN, dmem.dmemWEN}, 2'b00);
    @(posedge CLK);
    #1;
    check_eq("done_pulse", done, 1'b0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("rdata%0d", i), lane_rdata[i], model_rdata[i]);
    check_eq("acc_count", acc_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
      check_eq($sformatf("acc%0d_we", i), acc_log[i].we, exp_q[i].we);
      check_eq($sformatf("acc%0d_addr", i), acc_log[i].addr, exp_q[i].addr);
      check_eq($sformatf("acc%0d_data", i), acc_log[i].data, exp_q[i].data);
    end
  endtask

  task automatic run_err();
    logic both;
    acc_log.delete();
    both = 1'($urandom_range(0, 1));
    @(negedge CLK);
    start     = 1'b1;
    ren       = both;
    wen       = both;
    lane_mask = 4'b1111;
    #1;
    check_eq("err_pulse", err, 1'b1);
    check_eq("err_stall", stall, 1'b1);
    check_eq("err_no_strobe", {dmem.dmemREN, dmem.dmemWEN}, 2'b00);
    @(posedge CLK);
    #1;
    start = 1'b0;
    ren   = 1'b0;
    wen   = 1'b0;
    #1;
    check_eq("err_cleared", err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_eq("err_no_done", done, 1'b0);
    end
    check_eq("err_no_access", acc_log.size(), 0);
  endtask

  initial begin
    int cyc;
    nRST       = 1'b0;
    start      = 1'b0;
    ren        = 1'b0;
    wen        = 1'b0;
    lane_mask  = '0;
    lane_addr  = '0;
    lane_wdata = '0;
    for (int i = 0; i < 4; i++) model_rdata[i] = '0;
    #12;
    check_eq("rst_strobes", {dmem.dmemREN, dmem.dmemWEN}, 2'b00);
    check_eq("rst_done_stall_err", {done, stall, err}, 3'b000);
    check_eq("rst_lane_wen", lane_wen, 4'b0000);
    for (int i = 0; i < 4; i++) check_eq("rst_rdata", lane_rdata[i], 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Full-mask load, single-cycle hits.
    for (int i = 0; i < 4; i++) op_addr[i] = 32'h100 + 32'(4 * i);
    run_op(1'b1, 4'b1111, 0);

    // Sparse store with wait states.
    for (int i = 0; i < 4; i++) begin
      op_addr[i]  = 32'h180 + 32'(4 * i);
      op_wdata[i] = $urandom;
    end
    run_op(1'b0, 4'b0101, 2);

    // Read back the stored lanes plus untouched ones.
    run_op(1'b1, 4'b1111, 1);

    // Empty mask.
    run_op(1'b1, 4'b0000, 0);

    // Malformed op.
    run_err();

    // Reset in the middle of a four-lane load.
    for (int i = 0; i < 4; i++) op_addr[i] = 32'h300 + 32'(4 * i);
    wait_cycles = 0;
    acc_log.delete();
    @(negedge CLK);
    start     = 1'b1;
    ren       = 1'b1;
    wen       = 1'b0;
    lane_mask = 4'b1111;
    for (int i = 0; i < 4; i++) lane_addr[i] = op_addr[i];
    @(posedge CLK);
    #1;
    start = 1'b0;
    ren   = 1'b0;
    cyc   = 0;
    while (acc_log.size() < 2 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check_eq("rst_mid_reached", acc_log.size() >= 2, 1'b1);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    check_eq("rstmid_strobes", {dmem.dmemREN, dmem.dmemWEN}, 2'b00);
    check_eq("rstmid_stall_done", {stall, done}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      model_rdata[i] = '0;
      check_eq("rstmid_rdata", lane_rdata[i], 32'h0);
    end
    @(negedge CLK);
    nRST = 1'b1;
    run_op(1'b1, 4'b1111, 0);

    // All lanes on one address.
    for (int i = 0; i < 4; i++) op_addr[i] = 32'h200;
    run_op(1'b1, 4'b1111, 0);

    // Randomized ops over a small address pool so repeats occur.
    for (int n = 0; n < 24; n++) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        op_addr[i]  = 32'h400 + 32'(4 * $urandom_range(0, 2));
        op_wdata[i] = $urandom;
      end
      run_op(r, 4'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
